// File: rtl/axi_fifo_buf.sv
// axi_fifo_buf: single-clock show-ahead FIFO with occupancy count,
// almost-full indication and a sticky overflow flag.
module axi_fifo_buf #(
  parameter int WIDTH     = 71,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                       fifo_clk,
  input  logic                       fifo_rst,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       pop_ready,
  output logic [$clog2(DEPTH+1)-1:0] entry_cnt,
  output logic                       almost_full,
  output logic                       ovf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_LVL);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             ovf_r;
  logic             push_fire_s;
  logic             pop_fire_s;

  // Pointer increment with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Handshake flags come from registered occupancy only.
  assign push_ready  = (cnt_r != CNT_FULL);
  assign pop_valid   = (cnt_r != {CW{1'b0}});
  assign push_fire_s = push_valid && push_ready;
  assign pop_fire_s  = pop_valid && pop_ready;
  assign entry_cnt   = cnt_r;
  assign almost_full = (cnt_r >= CNT_AFULL);
  assign ovf_err     = ovf_r;

  // Show-ahead head entry; forced to zero while empty.
  always_comb begin
    pop_data = {WIDTH{1'b0}};
    if (pop_valid) begin
      pop_data = mem_r[rd_ptr_r];
    end else begin
      pop_data = {WIDTH{1'b0}};
    end
  end

  // Storage array: cleared by reset only, written on an accepted push.
  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (!flush && push_fire_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow; reset beats flush beats traffic.
  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_fire_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_fire_s, pop_fire_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (push_valid && (cnt_r == CNT_FULL)) begin
        ovf_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_fifo_buf.sv
// Directed + random bench for axi_fifo_buf with a queue-based scoreboard.
module tb_axi_fifo_buf;

  localparam int W  = 71;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int CW = $clog2(D + 1);

  logic          fifo_clk = 1'b0;
  logic          fifo_rst = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          push_ready;
  logic          pop_valid;
  logic [W-1:0]  pop_data;
  logic          pop_ready = 1'b0;
  logic [CW-1:0] entry_cnt;
  logic          almost_full;
  logic          ovf_err;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;

  axi_fifo_buf #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
    .fifo_clk   (fifo_clk),
    .fifo_rst   (fifo_rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .entry_cnt  (entry_cnt),
    .almost_full(almost_full),
    .ovf_err    (ovf_err)
  );

  // Free-running clock.
  always #5 fifo_clk = ~fifo_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard state.
  task automatic check_state(input string tag);
    logic [W-1:0] exp_head;
    exp_head = (q.size() == 0) ? {W{1'b0}} : q[0];
    chk({tag, ".cnt"},  W'(entry_cnt),   W'(q.size()));
    chk({tag, ".prdy"}, W'(push_ready),  W'(q.size() != D));
    chk({tag, ".pval"}, W'(pop_valid),   W'(q.size() != 0));
    chk({tag, ".afull"},W'(almost_full), W'(q.size() >= AF));
    chk({tag, ".ovf"},  W'(ovf_err),     W'(m_ovf));
    chk({tag, ".data"}, pop_data,        exp_head);
  endtask

  // One clock: drive, check current outputs, advance the model across the edge.
  task automatic cycle(input string tag, input logic pv, input logic [W-1:0] pd,
                       input logic pr, input logic fl, input logic rs);
    logic push_f;
    logic pop_f;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
    fifo_rst   = rs;
    check_state(tag);
    push_f = pv && (q.size() != D);
    pop_f  = pr && (q.size() != 0);
    @(posedge fifo_clk);
    #1;
    if (rs || fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pv && (q.size() == D)) m_ovf = 1'b1;
      if (pop_f) void'(q.pop_front());
      if (push_f) q.push_back(pd);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {7'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    // Reset
    repeat (2) @(posedge fifo_clk);
    #1;
    fifo_rst = 1'b0;
    cycle("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill 1..4 then drain in order
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    cycle("full", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Full with push+pop: pop wins, overflow sticks
    for (int i = 1; i <= 4; i++) cycle("fill2", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    cycle("ovf", 1'b1, W'(5), 1'b1, 1'b0, 1'b0);
    chk("ovf.cnt3", W'(entry_cnt), W'(3));
    chk("ovf.set", W'(ovf_err), W'(1));
    for (int i = 0; i < 3; i++) cycle("ovf_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("ovf_sticky", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Empty push with pop_ready: no bypass
    cycle("empty_push", 1'b1, W'(10), 1'b1, 1'b0, 1'b0);
    chk("nobypass.data", pop_data, W'(10));
    cycle("empty_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Steady push+pop at occupancy 2 across pointer wrap
    cycle("occ2a", 1'b1, W'(16), 1'b0, 1'b0, 1'b0);
    cycle("occ2b", 1'b1, W'(17), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("stream", 1'b1, W'(18 + i), 1'b1, 1'b0, 1'b0);
      chk("stream.cnt", W'(entry_cnt), W'(2));
      chk("stream.lag", pop_data, W'(18 + i - 1));
    end
    cycle("stream_d1", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("stream_d2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush at occupancy 3 with overflow set and a push pending
    for (int i = 0; i < 4; i++) cycle("fill3", 1'b1, W'(32 + i), 1'b0, 1'b0, 1'b0);
    cycle("ovf3", 1'b1, W'(99), 1'b1, 1'b0, 1'b0);
    cycle("flush", 1'b1, W'(88), 1'b0, 1'b1, 1'b0);
    chk("flush.cnt", W'(entry_cnt), W'(0));
    chk("flush.ovf", W'(ovf_err), W'(0));
    cycle("post_flush", 1'b1, W'(119), 1'b0, 1'b0, 1'b0);
    cycle("post_flush_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with flush, push and pop active
    cycle("pre_rst_a", 1'b1, W'(65), 1'b0, 1'b0, 1'b0);
    cycle("pre_rst_b", 1'b1, W'(66), 1'b0, 1'b0, 1'b0);
    cycle("rst_all", 1'b1, W'(67), 1'b1, 1'b1, 1'b1);
    chk("rst.data", pop_data, {W{1'b0}});
    chk("rst.prdy", W'(push_ready), W'(1));
    cycle("after_rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 2) != 0), rnd_word(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), 1'b0);
    end
    for (int i = 0; i < D; i++) cycle("final_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("final", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
